// File: rtl/chip8_alu_sequencer.sv
// CHIP-8 8XYN sequencer: reads Vx/Vy, drives the shared ALU,
// writes the result to Vx and then the carry/borrow/shift-out flag to VF.
package chip8_pkg;
    typedef enum logic [2:0] {
        ALU_f_OR,
        ALU_f_AND,
        ALU_f_XOR,
        ALU_f_ADD,
        ALU_f_MINUS,
        ALU_f_RSHIFT,
        ALU_f_LSHIFT
    } ALU_f;
endpackage

module chip8_alu_sequencer
    import chip8_pkg::*;
#(
    parameter logic [3:0] FLAG_REG    = 4'hF,
    parameter bit         SHIFT_SRC_Y = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] opcode,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [3:0]  rf_raddr,
    input  logic [7:0]  rf_rdata,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [7:0]  rf_wdata,
    output logic [15:0] alu_in1,
    output logic [15:0] alu_in2,
    output ALU_f        alu_sel,
    input  logic [15:0] alu_out
);

    typedef enum logic [2:0] {
        IDLE,
        RD_X,
        RD_Y,
        EXEC,
        WR_RES,
        WR_VF,
        DONE
    } state_t;

    state_t      state_q;
    logic [3:0]  x_q;
    logic [3:0]  y_q;
    logic [3:0]  n_q;
    logic [7:0]  vx_q;
    logic        flag_q;
    logic        ready_q;
    logic        done_q;
    logic        err_q;
    logic [3:0]  rf_raddr_q;
    logic        rf_we_q;
    logic [3:0]  rf_waddr_q;
    logic [7:0]  rf_wdata_q;

    logic [7:0]  vy;
    logic [7:0]  shsrc;
    logic        flag_d;
    logic [7:0]  res_d;
    logic        legal;
    logic        flag_op;
    logic [15:0] in1_d;
    logic [15:0] in2_d;
    ALU_f        sel_d;
    logic        unused_alu_hi;

    assign unused_alu_hi = ^alu_out[15:9];

    assign legal = (opcode[15:12] == 4'h8) &&
                   ((opcode[3:0] <= 4'h7) || (opcode[3:0] == 4'hE));

    assign flag_op = (n_q == 4'h4) || (n_q == 4'h5) || (n_q == 4'h6) ||
                     (n_q == 4'h7) || (n_q == 4'hE);

    // Vy arrives on the read port during EXEC, so the ALU is driven combinationally
    assign vy    = rf_rdata;
    assign shsrc = SHIFT_SRC_Y ? vy : vx_q;
    assign res_d = alu_out[7:0];

    always_comb begin
        in1_d  = 16'h0000;
        in2_d  = 16'h0000;
        sel_d  = ALU_f_OR;
        flag_d = 1'b0;
        if (state_q == EXEC) begin
            case (n_q)
                4'h0: begin
                    in1_d = {8'h00, vy};
                end
                4'h1: begin
                    in1_d = {8'h00, vx_q};
                    in2_d = {8'h00, vy};
                end
                4'h2: begin
                    in1_d = {8'h00, vx_q};
                    in2_d = {8'h00, vy};
                    sel_d = ALU_f_AND;
                end
                4'h3: begin
                    in1_d = {8'h00, vx_q};
                    in2_d = {8'h00, vy};
                    sel_d = ALU_f_XOR;
                end
                4'h4: begin
                    in1_d  = {8'h00, vx_q};
                    in2_d  = {8'h00, vy};
                    sel_d  = ALU_f_ADD;
                    flag_d = alu_out[8];
                end
                4'h5: begin
                    in1_d  = {8'h00, vx_q};
                    in2_d  = {8'h00, vy};
                    sel_d  = ALU_f_MINUS;
                    flag_d = (vx_q >= vy);
                end
                4'h6: begin
                    in1_d  = {8'h00, shsrc};
                    in2_d  = 16'h0001;
                    sel_d  = ALU_f_RSHIFT;
                    flag_d = shsrc[0];
                end
                4'h7: begin
                    in1_d  = {8'h00, vy};
                    in2_d  = {8'h00, vx_q};
                    sel_d  = ALU_f_MINUS;
                    flag_d = (vy >= vx_q);
                end
                4'hE: begin
                    in1_d  = {8'h00, shsrc};
                    in2_d  = 16'h0001;
                    sel_d  = ALU_f_LSHIFT;
                    flag_d = shsrc[7];
                end
                default: begin
                    in1_d = 16'h0000;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            x_q        <= 4'h0;
            y_q        <= 4'h0;
            n_q        <= 4'h0;
            vx_q       <= 8'h00;
            flag_q     <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rf_raddr_q <= 4'h0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 4'h0;
            rf_wdata_q <= 8'h00;
        end else begin
            rf_we_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        x_q     <= opcode[11:8];
                        y_q     <= opcode[7:4];
                        n_q     <= opcode[3:0];
                        ready_q <= 1'b0;
                        if (legal) begin
                            state_q    <= RD_X;
                            rf_raddr_q <= opcode[11:8];
                            err_q      <= 1'b0;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end
                    end
                end
                RD_X: begin
                    state_q    <= RD_Y;
                    rf_raddr_q <= y_q;
                end
                RD_Y: begin
                    state_q <= EXEC;
                    vx_q    <= rf_rdata;
                end
                EXEC: begin
                    state_q    <= WR_RES;
                    flag_q     <= flag_d;
                    rf_we_q    <= 1'b1;
                    rf_waddr_q <= x_q;
                    rf_wdata_q <= res_d;
                end
                WR_RES: begin
                    // flag goes last so an X==FLAG_REG op leaves the flag behind
                    if (flag_op) begin
                        state_q    <= WR_VF;
                        rf_we_q    <= 1'b1;
                        rf_waddr_q <= FLAG_REG;
                        rf_wdata_q <= {7'b0, flag_q};
                    end else begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                WR_VF: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    err_q   <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready    = ready_q;
    assign done     = done_q;
    assign err      = err_q;
    assign rf_raddr = rf_raddr_q;
    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign alu_in1  = in1_d;
    assign alu_in2  = in2_d;
    assign alu_sel  = sel_d;

endmodule

// File: tb/tb_chip8_alu_sequencer.sv
// Directed bench for chip8_alu_sequencer: two instances (shift Vx / shift Vy)
// sharing stimulus, each with its own register file and ALU model.
module tb_chip8_alu_sequencer;
    import chip8_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] opcode = 16'h0000;

    logic        ready0, done0, err0, we0;
    logic [3:0]  raddr0, waddr0;
    logic [7:0]  rdata0, wdata0;
    logic [15:0] in1_0, in2_0, out0;
    ALU_f        sel0;

    logic        ready1, done1, err1, we1;
    logic [3:0]  raddr1, waddr1;
    logic [7:0]  rdata1, wdata1;
    logic [15:0] in1_1, in2_1, out1;
    ALU_f        sel1;

    logic [7:0]  rf0 [16];
    logic [7:0]  rf1 [16];
    logic        set_en = 1'b0;
    logic [3:0]  set_a = 4'h0;
    logic [7:0]  set_d = 8'h00;

    logic [14:0] obs [2][9];
    logic        rdy [2][9];
    logic [18:0] aluw [2];

    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    chip8_alu_sequencer #(.FLAG_REG(4'hF), .SHIFT_SRC_Y(1'b0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode),
        .ready(ready0), .done(done0), .err(err0),
        .rf_raddr(raddr0), .rf_rdata(rdata0), .rf_we(we0),
        .rf_waddr(waddr0), .rf_wdata(wdata0),
        .alu_in1(in1_0), .alu_in2(in2_0), .alu_sel(sel0), .alu_out(out0)
    );

    chip8_alu_sequencer #(.FLAG_REG(4'hF), .SHIFT_SRC_Y(1'b1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode),
        .ready(ready1), .done(done1), .err(err1),
        .rf_raddr(raddr1), .rf_rdata(rdata1), .rf_we(we1),
        .rf_waddr(waddr1), .rf_wdata(wdata1),
        .alu_in1(in1_1), .alu_in2(in2_1), .alu_sel(sel1), .alu_out(out1)
    );

    always @(posedge clk) begin
        rdata0 <= rf0[raddr0];
        rdata1 <= rf1[raddr1];
        if (we0) rf0[waddr0] <= wdata0;
        if (we1) rf1[waddr1] <= wdata1;
        if (set_en) begin
            rf0[set_a] <= set_d;
            rf1[set_a] <= set_d;
        end
    end

    function automatic logic [15:0] alu(ALU_f s, logic [15:0] a, logic [15:0] b);
        case (s)
            ALU_f_OR:     return a | b;
            ALU_f_AND:    return a & b;
            ALU_f_XOR:    return a ^ b;
            ALU_f_ADD:    return a + b;
            ALU_f_MINUS:  return a - b;
            ALU_f_RSHIFT: return a >> b;
            ALU_f_LSHIFT: return a << b;
            default:      return 16'h0000;
        endcase
    endfunction

    assign out0 = alu(sel0, in1_0, in2_0);
    assign out1 = alu(sel1, in1_1, in2_1);

    function automatic logic [14:0] pk(logic w, logic [3:0] a, logic [7:0] d,
                                       logic dn, logic er);
        return {w, w ? a : 4'h0, w ? d : 8'h00, dn, er};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic set_reg(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        set_en = 1'b1;
        set_a  = a;
        set_d  = d;
        @(negedge clk);
        set_en = 1'b0;
    endtask

    task automatic run_op(input logic [15:0] op, input int hold, input int rst_k);
        @(negedge clk);
        chk("ready_before", {ready1, ready0}, 2'b11);
        opcode = op;
        start  = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            obs[0][k] = pk(we0, waddr0, wdata0, done0, err0);
            obs[1][k] = pk(we1, waddr1, wdata1, done1, err1);
            rdy[0][k] = ready0;
            rdy[1][k] = ready1;
            if (k == 3) begin
                aluw[0] = {sel0, in1_0[7:0], in2_0[7:0]};
                aluw[1] = {sel1, in1_1[7:0], in2_1[7:0]};
            end
            if (k >= hold) start = 1'b0;
            if (k == rst_k) reset = 1'b1;
            if (k == rst_k + 1) reset = 1'b0;
        end
    endtask

    task automatic expect_seq(input string tag, input int inst,
                              input int ka, input logic [3:0] aa, input logic [7:0] da,
                              input int kb, input logic [3:0] ab, input logic [7:0] db,
                              input int kd, input logic e);
        logic [14:0] ex;
        for (int k = 1; k <= 8; k++) begin
            if (k == ka)      ex = pk(1'b1, aa, da, 1'b0, 1'b0);
            else if (k == kb) ex = pk(1'b1, ab, db, 1'b0, 1'b0);
            else              ex = pk(1'b0, 4'h0, 8'h00, k == kd, (k == kd) && e);
            chk($sformatf("%s_i%0d_k%0d", tag, inst, k), {17'h0, obs[inst][k]}, {17'h0, ex});
        end
        if (kd > 0 && kd < 8)
            chk($sformatf("%s_i%0d_ready", tag, inst),
                {rdy[inst][1], rdy[inst][kd + 1]}, 2'b01);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_ctl0", {ready0, done0, err0, we0}, 4'b1000);
        chk("rst_ctl1", {ready1, done1, err1, we1}, 4'b1000);
        chk("rst_addr", {raddr0, waddr0, wdata0}, 16'h0000);
        chk("rst_alu", {in1_0, in2_0}, 32'h0);
        chk("rst_sel", {29'h0, sel0}, {29'h0, ALU_f_OR});
        reset = 1'b0;

        set_reg(4'h3, 8'hF0);
        set_reg(4'h4, 8'h20);
        run_op(16'h8344, 1, 99);
        expect_seq("add", 0, 4, 4'h3, 8'h10, 5, 4'hF, 8'h01, 6, 1'b0);
        expect_seq("add", 1, 4, 4'h3, 8'h10, 5, 4'hF, 8'h01, 6, 1'b0);
        chk("add_exec_alu", {13'h0, aluw[0]}, {13'h0, ALU_f_ADD, 8'hF0, 8'h20});
        chk("add_v3", {24'h0, rf0[3]}, 32'h10);

        run_op(16'h8345, 1, 99);
        expect_seq("sub_borrow", 0, 4, 4'h3, 8'hF0, 5, 4'hF, 8'h00, 6, 1'b0);

        set_reg(4'h3, 8'h20);
        run_op(16'h8345, 1, 99);
        expect_seq("sub_eq", 0, 4, 4'h3, 8'h00, 5, 4'hF, 8'h01, 6, 1'b0);

        set_reg(4'h5, 8'h81);
        set_reg(4'h6, 8'h03);
        run_op(16'h856E, 1, 99);
        expect_seq("shl_vx", 0, 4, 4'h5, 8'h02, 5, 4'hF, 8'h01, 6, 1'b0);
        expect_seq("shl_vy", 1, 4, 4'h5, 8'h06, 5, 4'hF, 8'h00, 6, 1'b0);

        run_op(16'h8347, 1, 99);
        expect_seq("subn", 0, 4, 4'h3, 8'h20, 5, 4'hF, 8'h01, 6, 1'b0);

        set_reg(4'hF, 8'hFF);
        set_reg(4'h2, 8'h01);
        run_op(16'h8F24, 1, 99);
        expect_seq("vf_dst", 0, 4, 4'hF, 8'h00, 5, 4'hF, 8'h01, 6, 1'b0);
        chk("vf_final", {24'h0, rf0[15]}, 32'h01);

        set_reg(4'h1, 8'h37);
        run_op(16'h8122, 1, 99);
        expect_seq("and", 0, 4, 4'h1, 8'h01, 0, 4'h0, 8'h00, 5, 1'b0);

        run_op(16'h8129, 1, 99);
        expect_seq("ill_n", 0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 1, 1'b1);
        expect_seq("ill_n", 1, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 1, 1'b1);

        run_op(16'h5120, 1, 99);
        expect_seq("ill_op", 0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 1, 1'b1);

        run_op(16'h8123, 6, 99);
        expect_seq("xor_hold", 0, 4, 4'h1, 8'h00, 0, 4'h0, 8'h00, 5, 1'b0);
        chk("hold_idle", {rdy[0][7], rdy[0][8]}, 2'b11);

        set_reg(4'h3, 8'h55);
        run_op(16'h8340, 1, 99);
        expect_seq("ld", 0, 4, 4'h3, 8'h20, 0, 4'h0, 8'h00, 5, 1'b0);

        run_op(16'h8344, 1, 3);
        expect_seq("rst_mid", 0, 0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 0, 1'b0);
        chk("rst_mid_ready", {rdy[0][3], rdy[0][4]}, 2'b01);
        chk("rst_mid_v3", {24'h0, rf0[3]}, 32'h20);

        run_op(16'h8344, 1, 99);
        expect_seq("after_rst", 0, 4, 4'h3, 8'h40, 5, 4'hF, 8'h00, 6, 1'b0);

        run_op(16'h8346, 1, 99);
        expect_seq("shr_vx", 0, 4, 4'h3, 8'h20, 5, 4'hF, 8'h00, 6, 1'b0);
        expect_seq("shr_vy", 1, 4, 4'h3, 8'h10, 5, 4'hF, 8'h00, 6, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
